// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side bundle of the decode stage: valid/ready handshakes,
// flush, and the registered decoded fields.
interface decode_stage_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [4:0]      rs1_o;
  logic [4:0]      rs2_o;
  logic [4:0]      rd_o;
  logic [31:0]     imm_o;
  logic            alusrc_o;
  logic            asel_pc_o;
  logic [3:0]      aluop_o;
  logic            jal_o;
  logic            jalr_o;
  logic            branch_o;
  logic [2:0]      br_funct3_o;
  logic            mem_ren_o;
  logic            mem_wen_o;
  logic            mem_to_reg_o;
  logic [2:0]      mem_size_o;
  logic            reg_wen_o;
  logic            mul_o;
  logic [2:0]      muldiv_op_o;
  logic            illegal_o;

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rs1_o, rs2_o, rd_o, imm_o, alusrc_o,
           asel_pc_o, aluop_o, jal_o, jalr_o, branch_o, br_funct3_o, mem_ren_o,
           mem_wen_o, mem_to_reg_o, mem_size_o, reg_wen_o, mul_o, muldiv_op_o,
           illegal_o
  );

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rs1_o, rs2_o, rd_o, imm_o, alusrc_o,
           asel_pc_o, aluop_o, jal_o, jalr_o, branch_o, br_funct3_o, mem_ren_o,
           mem_wen_o, mem_to_reg_o, mem_size_o, reg_wen_o, mul_o, muldiv_op_o,
           illegal_o
  );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I/M decode stage: combinational decoder feeding an output
// register plus an optional one-entry skid buffer, with flush and illegal detection.
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int M_EXT = 1,
  parameter int SKID  = 1
) (
  input logic          clk,
  input logic          rst,
  decode_stage_if.slave bus
);
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SRA,
    ALU_SRL, ALU_SLL, ALU_SLT, ALU_EQ, ALU_SLTU, ALU_PASSB
  } alu_op_e;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        alusrc, asel_pc;
    alu_op_e     aluop;
    logic        jal, jalr, branch;
    logic [2:0]  br_funct3;
    logic        mem_ren, mem_wen, mem_to_reg;
    logic [2:0]  mem_size;
    logic        reg_wen, mul;
    logic [2:0]  muldiv_op;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    dec_t            d;
  } bundle_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  logic [31:0] inst;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        ill;
  dec_t        dec;

  assign inst = bus.in_inst;
  assign f3   = inst[14:12];
  assign f7   = inst[31:25];

  // NOTE: every field gets a default before the case so no path leaves a latch.
  always_comb begin
    dec     = '0;
    ill     = 1'b0;
    dec.rs1 = inst[19:15];
    dec.rs2 = inst[24:20];
    dec.rd  = inst[11:7];
    unique case (inst[6:0])
      OP_REG: begin
        dec.reg_wen = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'b000:  dec.aluop = ALU_ADD;
              3'b001:  dec.aluop = ALU_SLL;
              3'b010:  dec.aluop = ALU_SLT;
              3'b011:  dec.aluop = ALU_SLTU;
              3'b100:  dec.aluop = ALU_XOR;
              3'b101:  dec.aluop = ALU_SRL;
              3'b110:  dec.aluop = ALU_OR;
              default: dec.aluop = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'b000)      dec.aluop = ALU_SUB;
            else if (f3 == 3'b101) dec.aluop = ALU_SRA;
            else                   ill = 1'b1;
          end
          7'b0000001: begin
            dec.mul       = 1'b1;
            dec.muldiv_op = f3;
            ill           = (M_EXT == 0);
          end
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.alusrc  = 1'b1;
        dec.reg_wen = 1'b1;
        dec.imm     = {{20{inst[31]}}, inst[31:20]};
        case (f3)
          3'b000: dec.aluop = ALU_ADD;
          3'b010: dec.aluop = ALU_SLT;
          3'b011: dec.aluop = ALU_SLTU;
          3'b100: dec.aluop = ALU_XOR;
          3'b110: dec.aluop = ALU_OR;
          3'b111: dec.aluop = ALU_AND;
          3'b001: begin
            dec.aluop = ALU_SLL;
            ill       = (f7 != 7'b0000000);
          end
          default: begin
            dec.aluop = (f7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            ill       = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
        endcase
      end
      OP_LOAD: begin
        dec.alusrc     = 1'b1;
        dec.mem_ren    = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_wen    = 1'b1;
        dec.mem_size   = f3;
        dec.imm        = {{20{inst[31]}}, inst[31:20]};
        ill            = (f3 == 3'd3) || (f3 > 3'd5);
      end
      OP_STORE: begin
        dec.alusrc   = 1'b1;
        dec.mem_wen  = 1'b1;
        dec.mem_size = f3;
        dec.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        ill          = (f3 > 3'd2);
      end
      OP_BRANCH: begin
        dec.branch    = 1'b1;
        dec.br_funct3 = f3;
        dec.imm       = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        case (f3)
          3'b000, 3'b001: dec.aluop = ALU_EQ;
          3'b100, 3'b101: dec.aluop = ALU_SLT;
          3'b110, 3'b111: dec.aluop = ALU_SLTU;
          default:        ill = 1'b1;
        endcase
      end
      OP_JAL: begin
        dec.jal     = 1'b1;
        dec.asel_pc = 1'b1;
        dec.alusrc  = 1'b1;
        dec.reg_wen = 1'b1;
        dec.imm     = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_JALR: begin
        dec.jalr    = 1'b1;
        dec.alusrc  = 1'b1;
        dec.reg_wen = 1'b1;
        dec.imm     = {{20{inst[31]}}, inst[31:20]};
        ill         = (f3 != 3'b000);
      end
      OP_LUI: begin
        dec.alusrc  = 1'b1;
        dec.aluop   = ALU_PASSB;
        dec.reg_wen = 1'b1;
        dec.imm     = {inst[31:12], 12'h000};
      end
      OP_AUIPC: begin
        dec.alusrc  = 1'b1;
        dec.asel_pc = 1'b1;
        dec.reg_wen = 1'b1;
        dec.imm     = {inst[31:12], 12'h000};
      end
      default: ill = 1'b1;
    endcase
    // Illegal bundles still flow downstream but may not cause any side effect.
    if (ill) begin
      dec.illegal    = 1'b1;
      dec.reg_wen    = 1'b0;
      dec.mem_ren    = 1'b0;
      dec.mem_wen    = 1'b0;
      dec.mem_to_reg = 1'b0;
      dec.branch     = 1'b0;
      dec.jal        = 1'b0;
      dec.jalr       = 1'b0;
      dec.mul        = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_wen = 1'b0;
  end

  logic    out_valid_q, skid_valid_q;
  bundle_t out_q, skid_q, new_b;
  logic    ready_base, accept;

  assign new_b      = '{pc: bus.in_pc, d: dec};
  assign ready_base = (SKID != 0) ? !skid_valid_q : (!out_valid_q || bus.out_ready);
  assign bus.in_ready = ready_base && !rst && !bus.flush;
  assign accept     = bus.in_valid && bus.in_ready;

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: payload registers are reset as well so every field reads 0 after reset.
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (skid_valid_q) begin
      if (bus.out_ready) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= accept;
        if (accept) skid_q <= new_b;
      end
    end else if (!out_valid_q || bus.out_ready) begin
      out_valid_q <= accept;
      if (accept) out_q <= new_b;
    end else if (accept && (SKID != 0)) begin
      skid_q       <= new_b;
      skid_valid_q <= 1'b1;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = out_q.pc;
  assign bus.rs1_o        = out_q.d.rs1;
  assign bus.rs2_o        = out_q.d.rs2;
  assign bus.rd_o         = out_q.d.rd;
  assign bus.imm_o        = out_q.d.imm;
  assign bus.alusrc_o     = out_q.d.alusrc;
  assign bus.asel_pc_o    = out_q.d.asel_pc;
  assign bus.aluop_o      = out_q.d.aluop;
  assign bus.jal_o        = out_q.d.jal;
  assign bus.jalr_o       = out_q.d.jalr;
  assign bus.branch_o     = out_q.d.branch;
  assign bus.br_funct3_o  = out_q.d.br_funct3;
  assign bus.mem_ren_o    = out_q.d.mem_ren;
  assign bus.mem_wen_o    = out_q.d.mem_wen;
  assign bus.mem_to_reg_o = out_q.d.mem_to_reg;
  assign bus.mem_size_o   = out_q.d.mem_size;
  assign bus.reg_wen_o    = out_q.d.reg_wen;
  assign bus.mul_o        = out_q.d.mul;
  assign bus.muldiv_op_o  = out_q.d.muldiv_op;
  assign bus.illegal_o    = out_q.d.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with M extension and skid buffer,
// a second without the M extension fed the same stimulus.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.PC_W(32)) a ();
  decode_stage_if #(.PC_W(32)) b ();

  assign b.in_valid  = a.in_valid;
  assign b.in_inst   = a.in_inst;
  assign b.in_pc     = a.in_pc;
  assign b.flush     = a.flush;
  assign b.out_ready = a.out_ready;

  decode_stage #(.PC_W(32), .M_EXT(1), .SKID(1)) dut    (.clk(clk), .rst(rst), .bus(a));
  decode_stage #(.PC_W(32), .M_EXT(0), .SKID(1)) dut_nm (.clk(clk), .rst(rst), .bus(b));

  localparam logic [31:0] I_ADDI = 32'h00500093, I_MUL = 32'h022081B3,
                          I_LUI = 32'h123452B7, I_BNE = 32'hFE209EE3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
    a.in_valid = v;
    a.in_inst  = inst;
    a.in_pc    = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (a.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", a.out_valid); end
    total++; if (a.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", a.in_ready); end
    total++; if (a.out_pc !== 32'h0) begin bad++; $display("FAIL rst_out_pc got=%h exp=0", a.out_pc); end
    total++; if (a.imm_o !== 32'h0) begin bad++; $display("FAIL rst_imm got=%h exp=0", a.imm_o); end
    rst = 1'b0;
    tick();
    total++; if (a.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b exp=1", a.in_ready); end
    total++; if (a.out_valid !== 1'b0) begin bad++; $display("FAIL post_rst_out_valid got=%b exp=0", a.out_valid); end
  endtask

  task automatic test_back_to_back();
    a.out_ready = 1'b1;
    drive(1'b1, I_ADDI, 32'h100);
    tick();
    total++; if (a.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_addi_valid got=%b exp=1", a.out_valid); end
    total++; if (a.out_pc !== 32'h100) begin bad++; $display("FAIL b2b_addi_pc got=%h exp=100", a.out_pc); end
    total++; if (a.rd_o !== 5'd1) begin bad++; $display("FAIL b2b_addi_rd got=%0d exp=1", a.rd_o); end
    total++; if (a.imm_o !== 32'd5) begin bad++; $display("FAIL b2b_addi_imm got=%h exp=5", a.imm_o); end
    total++; if (a.aluop_o !== 4'd0) begin bad++; $display("FAIL b2b_addi_aluop got=%0d exp=0", a.aluop_o); end
    total++; if (a.alusrc_o !== 1'b1) begin bad++; $display("FAIL b2b_addi_alusrc got=%b exp=1", a.alusrc_o); end
    total++; if (a.reg_wen_o !== 1'b1) begin bad++; $display("FAIL b2b_addi_reg_wen got=%b exp=1", a.reg_wen_o); end
    drive(1'b1, I_MUL, 32'h104);
    tick();
    total++; if (a.out_pc !== 32'h104) begin bad++; $display("FAIL b2b_mul_pc got=%h exp=104", a.out_pc); end
    total++; if (a.rs1_o !== 5'd1 || a.rs2_o !== 5'd2 || a.rd_o !== 5'd3) begin
      bad++; $display("FAIL b2b_mul_regs got=%0d/%0d/%0d exp=1/2/3", a.rs1_o, a.rs2_o, a.rd_o); end
    total++; if (a.mul_o !== 1'b1) begin bad++; $display("FAIL b2b_mul_mul got=%b exp=1", a.mul_o); end
    total++; if (a.muldiv_op_o !== 3'd0) begin bad++; $display("FAIL b2b_mul_op got=%0d exp=0", a.muldiv_op_o); end
    total++; if (a.reg_wen_o !== 1'b1 || a.illegal_o !== 1'b0) begin
      bad++; $display("FAIL b2b_mul_wen_ill got=%b%b exp=10", a.reg_wen_o, a.illegal_o); end
    total++; if (b.illegal_o !== 1'b1 || b.out_valid !== 1'b1) begin
      bad++; $display("FAIL nomext_mul_ill_valid got=%b%b exp=11", b.illegal_o, b.out_valid); end
    total++; if (b.reg_wen_o !== 1'b0 || b.mem_wen_o !== 1'b0 || b.mul_o !== 1'b0) begin
      bad++; $display("FAIL nomext_mul_side got=%b%b%b exp=000", b.reg_wen_o, b.mem_wen_o, b.mul_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    total++; if (a.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain_valid got=%b exp=0", a.out_valid); end
  endtask

  task automatic test_lui_bne();
    drive(1'b1, I_LUI, 32'h110);
    tick();
    total++; if (a.imm_o !== 32'h12345000) begin bad++; $display("FAIL lui_imm got=%h exp=12345000", a.imm_o); end
    total++; if (a.aluop_o !== 4'd11) begin bad++; $display("FAIL lui_aluop got=%0d exp=11", a.aluop_o); end
    total++; if (a.reg_wen_o !== 1'b1 || a.rd_o !== 5'd5) begin
      bad++; $display("FAIL lui_wen_rd got=%b/%0d exp=1/5", a.reg_wen_o, a.rd_o); end
    drive(1'b1, I_BNE, 32'h114);
    tick();
    total++; if (a.imm_o !== 32'hFFFFFFFC) begin bad++; $display("FAIL bne_imm got=%h exp=fffffffc", a.imm_o); end
    total++; if (a.branch_o !== 1'b1 || a.br_funct3_o !== 3'd1) begin
      bad++; $display("FAIL bne_branch got=%b/%0d exp=1/1", a.branch_o, a.br_funct3_o); end
    total++; if (a.reg_wen_o !== 1'b0) begin bad++; $display("FAIL bne_reg_wen got=%b exp=0", a.reg_wen_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  typedef struct {
    logic [31:0] inst;
    logic        ill, wen, ren, mwen, chk_imm;
    logic [31:0] imm;
  } vec_t;

  task automatic test_field_edges();
    vec_t v[7];
    v[0] = '{32'h00100013, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1};   // addi x0,x0,1
    v[1] = '{32'h0080A103, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8};   // lw x2,8(x1)
    v[2] = '{32'h0020A623, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC};   // sw x2,12(x1)
    v[3] = '{32'h0080B103, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};   // load funct3=3
    v[4] = '{32'h4030D093, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h403}; // srai x1,x1,3
    v[5] = '{32'h40309093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};   // slli with funct7=0100000
    v[6] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    a.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, v[i].inst, 32'h300 + 32'(i * 4));
      tick();
      total++; if (a.out_valid !== 1'b1 || a.illegal_o !== v[i].ill) begin
        bad++; $display("FAIL edge%0d_valid_ill got=%b%b exp=1%b", i, a.out_valid, a.illegal_o, v[i].ill); end
      total++; if (a.reg_wen_o !== v[i].wen || a.mem_ren_o !== v[i].ren || a.mem_wen_o !== v[i].mwen || a.mul_o !== 1'b0) begin
        bad++; $display("FAIL edge%0d_ctrl got=%b%b%b%b exp=%b%b%b0", i, a.reg_wen_o, a.mem_ren_o, a.mem_wen_o,
                        a.mul_o, v[i].wen, v[i].ren, v[i].mwen); end
      if (v[i].chk_imm) begin
        total++; if (a.imm_o !== v[i].imm) begin bad++; $display("FAIL edge%0d_imm got=%h exp=%h", i, a.imm_o, v[i].imm); end
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_skid_stall();
    a.out_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h200);
    tick();
    total++; if (a.out_valid !== 1'b1 || a.out_pc !== 32'h200) begin
      bad++; $display("FAIL skid_first_out got=%b/%h exp=1/200", a.out_valid, a.out_pc); end
    total++; if (a.in_ready !== 1'b1) begin bad++; $display("FAIL skid_ready_1 got=%b exp=1", a.in_ready); end
    drive(1'b1, I_MUL, 32'h204);
    tick();
    total++; if (a.in_ready !== 1'b0) begin bad++; $display("FAIL skid_ready_full got=%b exp=0", a.in_ready); end
    drive(1'b1, I_LUI, 32'h208);
    tick();
    total++; if (a.in_ready !== 1'b0 || a.out_pc !== 32'h200 || a.rd_o !== 5'd1) begin
      bad++; $display("FAIL skid_hold got=%b/%h/%0d exp=0/200/1", a.in_ready, a.out_pc, a.rd_o); end
    a.out_ready = 1'b1;
    tick();
    total++; if (a.out_valid !== 1'b1 || a.out_pc !== 32'h204 || a.mul_o !== 1'b1) begin
      bad++; $display("FAIL skid_rel_2nd got=%b/%h/%b exp=1/204/1", a.out_valid, a.out_pc, a.mul_o); end
    total++; if (a.in_ready !== 1'b1) begin bad++; $display("FAIL skid_rel_ready got=%b exp=1", a.in_ready); end
    tick();
    total++; if (a.out_valid !== 1'b1 || a.out_pc !== 32'h208 || a.imm_o !== 32'h12345000) begin
      bad++; $display("FAIL skid_rel_3rd got=%b/%h/%h exp=1/208/12345000", a.out_valid, a.out_pc, a.imm_o); end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    total++; if (a.out_valid !== 1'b0) begin bad++; $display("FAIL skid_empty got=%b exp=0", a.out_valid); end
  endtask

  task automatic test_flush();
    a.out_ready = 1'b1;
    a.flush = 1'b1;
    #1;
    total++; if (a.in_ready !== 1'b0) begin bad++; $display("FAIL flush_idle_ready got=%b exp=0", a.in_ready); end
    a.flush = 1'b0;
    a.out_ready = 1'b0;
    drive(1'b1, I_ADDI, 32'h400);
    tick();
    drive(1'b1, I_MUL, 32'h404);
    tick();
    drive(1'b1, I_LUI, 32'h408);
    a.flush = 1'b1;
    #1;
    total++; if (a.in_ready !== 1'b0) begin bad++; $display("FAIL flush_ready_during got=%b exp=0", a.in_ready); end
    tick();
    a.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    total++; if (a.out_valid !== 1'b0 || a.in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_after got=%b/%b exp=0/1", a.out_valid, a.in_ready); end
    a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (a.out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost%0d got=%b/%h exp=0", i, a.out_valid, a.out_pc); end
    end
  endtask

  task automatic test_reset_mid_stall();
    a.out_ready = 1'b0;
    drive(1'b1, I_LUI, 32'h500);
    tick();
    drive(1'b1, I_MUL, 32'h504);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    total++; if (a.out_valid !== 1'b0 || a.in_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_valid_ready got=%b/%b exp=0/0", a.out_valid, a.in_ready); end
    total++; if (a.out_pc !== 32'h0 || a.imm_o !== 32'h0 || a.rd_o !== 5'd0 || a.reg_wen_o !== 1'b0 || a.aluop_o !== 4'd0) begin
      bad++; $display("FAIL rstmid_fields got=%h/%h/%0d/%b/%0d exp=0", a.out_pc, a.imm_o, a.rd_o, a.reg_wen_o, a.aluop_o); end
    rst = 1'b0;
    a.out_ready = 1'b1;
    tick();
    total++; if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0) begin
      bad++; $display("FAIL rstmid_after got=%b/%b exp=1/0", a.in_ready, a.out_valid); end
    tick();
    total++; if (a.out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_skid got=%b exp=0", a.out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1;
    a.flush = 1'b0;
    a.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    test_reset();
    test_back_to_back();
    test_lui_bne();
    test_field_edges();
    test_skid_stall();
    test_flush();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
